// File: rtl/sram_bus_pkg.sv
// sram_bus_pkg: shared state type, default sizes and limits for the SRAM bus controller
package sram_bus_pkg;
  typedef enum logic [2:0] {IDLE, SETUP, STROBE, HOLD, TURN} state_t;
  localparam int DEF_ADDR_WIDTH = 8;
  localparam int DEF_DATA_WIDTH = 16;
  localparam int DEF_WAIT_STATES = 1;
  localparam int DEF_TURNAROUND = 1;
  localparam int MAX_WAIT_STATES = 15;
  localparam int MAX_TURNAROUND = 3;
  function automatic int ctr_width(input int n);
    return (n < 1) ? 1 : $clog2(n + 1);
  endfunction
endpackage

// File: rtl/flopenr.sv
// flopenr: two-phase master/slave register with enable and synchronous reset
module flopenr #(
  parameter int WIDTH = 1
) (
  input  logic             ph1,
  input  logic             ph2,
  input  logic             reset,
  input  logic             en,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);
  logic [WIDTH-1:0] m;
  // master captures d when enabled, otherwise recirculates q; reset wins
  always_ff @(posedge ph2) m <= reset ? '0 : (en ? d : q);
  // slave publishes the master value in ph1
  always_ff @(posedge ph1) q <= m;
endmodule

// File: rtl/flopr.sv
// flopr: two-phase master/slave register with synchronous reset
module flopr #(
  parameter int WIDTH = 1
) (
  input  logic             ph1,
  input  logic             ph2,
  input  logic             reset,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);
  logic [WIDTH-1:0] m;
  // master captures next value in ph2, reset taking priority
  always_ff @(posedge ph2) m <= reset ? '0 : d;
  // slave publishes the master value in ph1
  always_ff @(posedge ph1) q <= m;
endmodule

// File: rtl/sram_wait_ctr.sv
// sram_wait_ctr: loadable down-counter with zero flag on the two-phase clock
module sram_wait_ctr #(
  parameter int WIDTH = 1
) (
  input  logic             ph1,
  input  logic             ph2,
  input  logic             reset,
  input  logic             load,
  input  logic             dec,
  input  logic [WIDTH-1:0] load_val,
  output logic             zero
);
  logic [WIDTH-1:0] count, count_n;
  // load wins over decrement; the count parks at zero
  always_comb count_n = load ? load_val : (dec && !zero) ? count - 1'b1 : count;
  flopr #(.WIDTH(WIDTH)) u_cnt (.ph1(ph1), .ph2(ph2), .reset(reset), .d(count_n), .q(count));
  assign zero = count == '0;
endmodule

// File: rtl/sram_bus_ctrl.sv
// sram_bus_ctrl: single-access asynchronous SRAM bus controller with wait states and read turnaround
module sram_bus_ctrl
  import sram_bus_pkg::*;
#(
  parameter int ADDR_WIDTH  = DEF_ADDR_WIDTH,
  parameter int DATA_WIDTH  = DEF_DATA_WIDTH,
  parameter int WAIT_STATES = DEF_WAIT_STATES,
  parameter int TURNAROUND  = DEF_TURNAROUND
) (
  input  logic                  ph1,
  input  logic                  ph2,
  input  logic                  reset,
  input  logic                  req,
  input  logic                  wr,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [DATA_WIDTH-1:0] wdata,
  output logic                  ready,
  output logic                  rvalid,
  output logic [DATA_WIDTH-1:0] rdata,
  output logic [ADDR_WIDTH-1:0] sram_adr,
  output logic [DATA_WIDTH-1:0] sram_dout,
  input  logic [DATA_WIDTH-1:0] sram_din,
  output logic                  sram_drive,
  output logic                  ce_n,
  output logic                  oe_n,
  output logic                  we_n
);
  localparam int CW = ctr_width(WAIT_STATES);
  localparam int TW = ctr_width(MAX_TURNAROUND);
  localparam logic [CW-1:0] WS_LD = CW'(WAIT_STATES);
  localparam logic [TW-1:0] TA_LD = TW'(TURNAROUND == 0 ? 0 : TURNAROUND - 1);
  state_t state, state_n;
  logic [2:0] state_q;
  logic wr_q, take, act, w_zero, t_zero;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  flopr #(.WIDTH(3)) u_state (.ph1(ph1), .ph2(ph2), .reset(reset), .d(state_n), .q(state_q));
  assign state = state_t'(state_q);
  flopenr #(.WIDTH(1)) u_wr (.ph1(ph1), .ph2(ph2), .reset(reset), .en(take), .d(wr), .q(wr_q));
  flopenr #(.WIDTH(ADDR_WIDTH)) u_addr (.ph1(ph1), .ph2(ph2), .reset(reset), .en(take), .d(addr), .q(addr_q));
  flopenr #(.WIDTH(DATA_WIDTH)) u_wdata (.ph1(ph1), .ph2(ph2), .reset(reset), .en(take), .d(wdata), .q(wdata_q));
  flopenr #(.WIDTH(DATA_WIDTH)) u_rdata (.ph1(ph1), .ph2(ph2), .reset(reset),
    .en(state == STROBE && !wr_q && w_zero), .d(sram_din), .q(rdata));
  sram_wait_ctr #(.WIDTH(CW)) u_wait (.ph1(ph1), .ph2(ph2), .reset(reset), .load(state == SETUP),
    .dec(state == STROBE), .load_val(WS_LD), .zero(w_zero));
  sram_wait_ctr #(.WIDTH(TW)) u_turn (.ph1(ph1), .ph2(ph2), .reset(reset), .load(state == HOLD),
    .dec(state == TURN), .load_val(TA_LD), .zero(t_zero));
  assign sram_adr = addr_q;
  assign sram_dout = wdata_q;
  // next state and Moore bus strobes; the address/data bus is held from the latched request
  always_comb begin
    act = state inside {SETUP, STROBE, HOLD};
    ready = state == IDLE;
    take = ready && req;
    ce_n = !act;
    oe_n = !(act && !wr_q);
    we_n = !(state == STROBE && wr_q);
    sram_drive = act && wr_q;
    rvalid = state == HOLD && !wr_q;
    state_n = state == IDLE ? (req ? SETUP : IDLE)
            : state == SETUP ? STROBE
            : state == STROBE ? (w_zero ? HOLD : STROBE)
            : state == HOLD ? ((wr_q || TURNAROUND == 0) ? IDLE : TURN)
            : t_zero ? IDLE : TURN;
  end
endmodule

// File: tb/tb_sram_bus_ctrl.sv
// tb_sram_bus_ctrl: directed stimulus with an access-level model and literal expectations
module tb_sram_bus_ctrl;
  localparam int W = 1, T = 1;
  logic ph1 = 0, ph2 = 0, reset = 1;
  logic req = 0, wr = 0;
  logic [7:0] addr = 0, sram_adr;
  logic [15:0] wdata = 0, rdata, sram_dout, sram_din;
  logic ready, rvalid, sram_drive, ce_n, oe_n, we_n;
  logic req2 = 0;
  logic [7:0] addr2 = 0, sram_adr2;
  logic [15:0] rdata2, sram_dout2, sram_din2;
  logic ready2, rvalid2, sram_drive2, ce_n2, oe_n2, we_n2;
  logic [15:0] mem [256];
  logic [15:0] mem_m [256];
  bit mon, busy;
  int k;
  logic m_wr;
  logic [7:0] m_addr;
  logic [15:0] m_wdata, m_rdata;
  bit act_e;
  int checks = 0, errors = 0;
  logic [15:0] ob_ready, ob_ce, ob_oe, ob_we, ob_drv, ob_rv, rd_cap, adr1, dout3;
  logic [15:0] ob2_ready, ob2_oe, ob2_rv, rd2;

  sram_bus_ctrl #(.ADDR_WIDTH(8), .DATA_WIDTH(16), .WAIT_STATES(W), .TURNAROUND(T)) dut (
    .ph1(ph1), .ph2(ph2), .reset(reset), .req(req), .wr(wr), .addr(addr), .wdata(wdata),
    .ready(ready), .rvalid(rvalid), .rdata(rdata), .sram_adr(sram_adr), .sram_dout(sram_dout),
    .sram_din(sram_din), .sram_drive(sram_drive), .ce_n(ce_n), .oe_n(oe_n), .we_n(we_n));

  sram_bus_ctrl #(.ADDR_WIDTH(8), .DATA_WIDTH(16), .WAIT_STATES(0), .TURNAROUND(0)) dut2 (
    .ph1(ph1), .ph2(ph2), .reset(reset), .req(req2), .wr(1'b0), .addr(addr2), .wdata(16'h0000),
    .ready(ready2), .rvalid(rvalid2), .rdata(rdata2), .sram_adr(sram_adr2), .sram_dout(sram_dout2),
    .sram_din(sram_din2), .sram_drive(sram_drive2), .ce_n(ce_n2), .oe_n(oe_n2), .we_n(we_n2));

  initial forever begin #5 ph1 = 1; #5 ph1 = 0; #5 ph2 = 1; #5 ph2 = 0; end

  assign sram_din = !oe_n ? mem[sram_adr] : 16'h0000;
  assign sram_din2 = (!oe_n2 && sram_adr2 == 8'hFF) ? 16'hBEEF : 16'h0000;

  always @(posedge ph2) if (!ce_n && !we_n && sram_drive) mem[sram_adr] <= sram_dout;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, got, exp);
    end
  endtask

  // access-level model: k counts cycles since acceptance; an access lasts W+3 cycles, reads add T
  always @(posedge ph2) begin
    if (reset) begin
      mon <= 1;
      busy <= 0;
      m_rdata <= 0;
    end else if (mon) begin
      if (busy) begin
        if (k == (m_wr ? W + 3 : W + 3 + T)) busy <= 0;
        else begin
          k <= k + 1;
          if (k + 1 == 2 && m_wr) mem_m[m_addr] <= m_wdata;
          if (k + 1 == W + 3 && !m_wr) m_rdata <= mem_m[m_addr];
        end
      end else if (req) begin
        busy <= 1;
        k <= 1;
        m_wr <= wr;
        m_addr <= addr;
        m_wdata <= wdata;
      end
    end
  end

  always @(posedge ph1) begin
    #7;
    if (mon) begin
      act_e = busy && k <= W + 3;
      chk("ready", ready, !busy);
      chk("ce_n", ce_n, !act_e);
      chk("oe_n", oe_n, !(act_e && !m_wr));
      chk("we_n", we_n, !(busy && m_wr && k >= 2 && k <= W + 2));
      chk("drive", sram_drive, act_e && m_wr);
      chk("rvalid", rvalid, busy && !m_wr && k == W + 3);
      chk("rdata", rdata, m_rdata);
      chk("inv_drive_oe", sram_drive && !oe_n, 0);
      chk("inv_we", !we_n && !(!ce_n && sram_drive), 0);
      if (act_e) chk("sram_adr", sram_adr, m_addr);
      if (act_e && m_wr) chk("sram_dout", sram_dout, m_wdata);
    end
  end

  task automatic clr();
    ob_ready = 0; ob_ce = 0; ob_oe = 0; ob_we = 0; ob_drv = 0; ob_rv = 0; rd_cap = 0;
  endtask

  task automatic step(input int c, input logic r, input logic w, input logic [7:0] a,
                      input logic [15:0] d, input logic rst);
    @(posedge ph1);
    #1;
    reset = rst; req = r; wr = w; addr = a; wdata = d;
    #6;
    ob_ready[c] = ready; ob_ce[c] = ce_n; ob_oe[c] = oe_n; ob_we[c] = we_n;
    ob_drv[c] = sram_drive; ob_rv[c] = rvalid;
    if (rvalid) rd_cap = rdata;
    if (c == 1) adr1 = {8'h00, sram_adr};
    if (c == 3) dout3 = sram_dout;
  endtask

  task automatic step2(input int c, input logic r, input logic [7:0] a);
    @(posedge ph1);
    #1;
    req2 = r; addr2 = a;
    #6;
    ob2_ready[c] = ready2; ob2_oe[c] = oe_n2; ob2_rv[c] = rvalid2;
    if (rvalid2) rd2 = rdata2;
    chk("d2_bus_quiet", {sram_drive2, we_n2, sram_dout2}, {1'b0, 1'b1, 16'h0000});
    chk("d2_ce_oe", ce_n2, oe_n2);
  endtask

  initial begin
    clr();
    step(0, 0, 0, 8'h00, 16'h0000, 1);
    step(1, 0, 0, 8'h00, 16'h0000, 1);
    step(2, 0, 0, 8'h00, 16'h0000, 0);
    chk("rst_ready", ob_ready[2], 1);
    chk("rst_strobes", {ob_ce[2], ob_oe[2], ob_we[2], ob_drv[2]}, 4'b1110);
    chk("rst_rdata", rdata, 16'h0000);
    chk("rst_ready2", ready2, 1);

    clr();
    step(0, 1, 1, 8'h20, 16'h002D, 0);
    for (int i = 1; i < 7; i++) step(i, 0, 1, 8'h20, 16'h002D, 0);
    chk("wr_ce_n", ob_ce[6:0], 7'b1100001);
    chk("wr_we_n", ob_we[6:0], 7'b1110011);
    chk("wr_drive", ob_drv[6:0], 7'b0011110);
    chk("wr_ready", ob_ready[6:0], 7'b1100001);
    chk("wr_adr", adr1, 16'h0020);
    chk("wr_dout", dout3, 16'h002D);

    clr();
    step(0, 1, 0, 8'h20, 16'h0000, 0);
    for (int i = 1; i < 7; i++) step(i, 0, 0, 8'h20, 16'h0000, 0);
    chk("rd_oe_n", ob_oe[6:0], 7'b1100001);
    chk("rd_rvalid", ob_rv[6:0], 7'b0010000);
    chk("rd_ready", ob_ready[6:0], 7'b1000001);
    chk("rd_we_drive", {ob_we[6:0], ob_drv[6:0]}, {7'b1111111, 7'b0000000});
    chk("rd_data", rd_cap, 16'h002D);

    clr();
    step(0, 1, 1, 8'h31, 16'h1234, 0);
    for (int i = 1; i < 6; i++) step(i, 1, 0, 8'h31, 16'h0000, 0);
    for (int i = 6; i < 13; i++) step(i, 0, 0, 8'h31, 16'h0000, 0);
    chk("b2b_ready", ob_ready[12:0], 13'b1_1000_0010_0001);
    chk("b2b_ce_n", ob_ce[12:0], 13'b1_1100_0010_0001);
    chk("b2b_rvalid", ob_rv[12:0], 13'h0200);
    chk("b2b_rdata", rd_cap, 16'h1234);

    clr();
    step(0, 1, 1, 8'h40, 16'h55AA, 0);
    step(1, 0, 1, 8'h40, 16'h55AA, 0);
    step(2, 0, 1, 8'h40, 16'h55AA, 1);
    for (int i = 3; i < 6; i++) step(i, 0, 1, 8'h40, 16'h55AA, 0);
    chk("abort_we_before", ob_we[2], 0);
    chk("abort_bus", {ob_we[3], ob_ce[3], ob_drv[3], ob_ready[3]}, 4'b1101);
    chk("abort_no_rvalid", ob_rv[5:0], 0);
    chk("abort_rdata", rdata, 16'h0000);

    ob2_ready = 0; ob2_oe = 0; ob2_rv = 0; rd2 = 0;
    step2(0, 1, 8'hFF);
    for (int i = 1; i < 5; i++) step2(i, 0, 8'hFF);
    chk("w0_rvalid", ob2_rv[4:0], 5'b01000);
    chk("w0_ready", ob2_ready[4:0], 5'b10001);
    chk("w0_oe_n", ob2_oe[4:0], 5'b10001);
    chk("w0_rdata", rd2, 16'hBEEF);

    step(0, 0, 0, 8'h00, 16'h0000, 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
